// File: rtl/lin_rec_pkg.sv
// Shared types and helpers for the order-2 linear recurrence generator.
//   state_t      : generator FSM states
//   full_width() : bit width of the full-precision sum of two products
//   sat_trunc()  : reduces a full-precision signed sum to a WIDTH-bit term,
//                  returning {ovf, value}; value lives in the low WIDTH bits
package lin_rec_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   // Upper bounds supported by sat_trunc; instances use WIDTH <= MAX_W, CW <= MAX_CW.
   localparam int unsigned MAX_W    = 64;
   localparam int unsigned MAX_CW   = 16;
   localparam int unsigned FULL_MAX = MAX_W + MAX_CW + 1;

   localparam logic signed [FULL_MAX-1:0] FULL_ONE = {{(FULL_MAX-1){1'b0}}, 1'b1};

   function automatic int unsigned full_width(input int unsigned width, input int unsigned cw);
      return width + cw + 1;
   endfunction

   function automatic logic [MAX_W:0] sat_trunc(input logic signed [FULL_MAX-1:0] full,
                                                input int unsigned             width,
                                                input logic                    saturate);
      logic signed [FULL_MAX-1:0] hi;
      logic signed [FULL_MAX-1:0] lo;
      logic                       ovf;
      logic [MAX_W-1:0]           val;
      hi  = (FULL_ONE <<< (width - 1)) - FULL_ONE;
      lo  = ~hi;  // -hi-1, the most negative WIDTH-bit value
      ovf = (full > hi) || (full < lo);
      if (saturate && ovf) begin
         val = full[FULL_MAX-1] ? lo[MAX_W-1:0] : hi[MAX_W-1:0];
      end else begin
         val = full[MAX_W-1:0];
      end
      return {ovf, val};
   endfunction

endpackage

// File: rtl/lin_rec_gen_step.sv
// Combinational recurrence step: next = coef_1*b + coef_0*a, reduced to WIDTH bits.
//   a, b           in   WIDTH  x[k], x[k+1] (signed)
//   coef_0, coef_1 in   CW     weights of a and b (signed)
//   next           out  WIDTH  x[k+2] after wrap/saturate
//   ovf            out  1      full-precision result was outside signed WIDTH range
module lin_rec_step
   import lin_rec_pkg::*;
#(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned CW       = 8,
   parameter int unsigned SATURATE = 0
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [CW-1:0]    coef_0,
   input  logic [CW-1:0]    coef_1,
   output logic [WIDTH-1:0] next,
   output logic             ovf
);

   localparam int unsigned FW = full_width(WIDTH, CW);

   logic signed [FW-1:0] full;
   logic [MAX_W:0]       sat_res;

   always_comb begin
      full    = FW'($signed(coef_1)) * FW'($signed(b)) + FW'($signed(coef_0)) * FW'($signed(a));
      sat_res = sat_trunc(FULL_MAX'(full), WIDTH, SATURATE != 0);
      next    = sat_res[WIDTH-1:0];
      ovf     = sat_res[MAX_W];
   end

   if (WIDTH < MAX_W) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^sat_res[MAX_W-1:WIDTH];
   end

endmodule

// File: rtl/lin_rec_gen.sv
// Streams the first n terms of x[k+2] = coef_1*x[k+1] + coef_0*x[k] from seeds.
//   __clock, __reset_n      clock / synchronous active-low reset
//   __start                 load inputs and begin a run (IDLE/DONE only)
//   __ready                 consumer accepts __output_0 this cycle
//   n, seed_a, seed_b       term count, x[0], x[1] (signed, WIDTH)
//   coef_0, coef_1          weights of x[k], x[k+1] (signed, CW)
//   __valid, __output_0     presented term x[__index]
//   __index                 index of presented term
//   __done                  all terms transferred
//   __overflow              sticky: an emitted term overflowed this run
module lin_rec_gen
   import lin_rec_pkg::*;
#(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned CW       = 8,
   parameter int unsigned SATURATE = 0
) (
   input  logic             __clock,
   input  logic             __reset_n,
   input  logic             __start,
   input  logic             __ready,
   input  logic [WIDTH-1:0] n,
   input  logic [WIDTH-1:0] seed_a,
   input  logic [WIDTH-1:0] seed_b,
   input  logic [CW-1:0]    coef_0,
   input  logic [CW-1:0]    coef_1,
   output logic             __valid,
   output logic [WIDTH-1:0] __output_0,
   output logic [WIDTH-1:0] __index,
   output logic             __done,
   output logic             __overflow
);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_q, b_q, index_q, rem_q;
   logic             a_ovf_q, b_ovf_q, overflow_q;
   logic [CW-1:0]    c0_q, c1_q;
   logic [WIDTH-1:0] step_val;
   logic             step_ovf;
   logic             load, xfer, last, n_pos;

   lin_rec_step #(.WIDTH(WIDTH), .CW(CW), .SATURATE(SATURATE)) u_step (
      .a      (a_q),
      .b      (b_q),
      .coef_0 (c0_q),
      .coef_1 (c1_q),
      .next   (step_val),
      .ovf    (step_ovf)
   );

   always_comb begin
      n_pos     = !n[WIDTH-1] && (n != '0);
      __valid   = (state == RUN);
      __done    = (state == DONE);
      xfer      = __valid && __ready;
      last      = (rem_q == WIDTH'(1));
      load      = __start && (state != RUN);
      state_nxt = state;
      unique case (state)
         IDLE, DONE: if (__start) state_nxt = n_pos ? RUN : DONE;
         RUN:        if (xfer && last) state_nxt = DONE;
         default:    state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge __clock) begin
      if (!__reset_n) state <= IDLE;
      else            state <= state_nxt;
   end

   always_ff @(posedge __clock) begin
      if (!__reset_n) begin
         a_q        <= '0;
         b_q        <= '0;
         a_ovf_q    <= 1'b0;
         b_ovf_q    <= 1'b0;
         index_q    <= '0;
         rem_q      <= '0;
         overflow_q <= 1'b0;
         c0_q       <= '0;
         c1_q       <= '0;
      end else if (load) begin
         a_q        <= seed_a;
         b_q        <= seed_b;
         a_ovf_q    <= 1'b0;
         b_ovf_q    <= 1'b0;
         index_q    <= '0;
         rem_q      <= n;
         overflow_q <= 1'b0;
         c0_q       <= coef_0;
         c1_q       <= coef_1;
      end else if (xfer) begin
         a_q     <= b_q;
         a_ovf_q <= b_ovf_q;
         b_q     <= step_val;
         b_ovf_q <= step_ovf;
         index_q <= index_q + WIDTH'(1);
         rem_q   <= rem_q - WIDTH'(1);
         // the term shifted in by the final transfer is never presented
         if (b_ovf_q && !last) overflow_q <= 1'b1;
      end
   end

   assign __output_0 = a_q;
   assign __index    = index_q;
   assign __overflow = overflow_q;

endmodule

// File: tb/tb_lin_rec_gen.sv
module tb_lin_rec_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n = 1'b0;
   logic        start   = 1'b0;
   logic        ready   = 1'b1;
   logic [31:0] n_in    = '0;
   logic [31:0] sa_in   = '0;
   logic [31:0] sb_in   = '0;
   logic [7:0]  c0_in   = '0;
   logic [7:0]  c1_in   = '0;
   int          sel     = 0;

   logic               v32, d32, o32;
   logic signed [31:0] out32;
   logic [31:0]        idx32;
   logic               v8w, d8w, o8w;
   logic signed [7:0]  out8w;
   logic [7:0]         idx8w;
   logic               v8s, d8s, o8s;
   logic signed [7:0]  out8s;
   logic [7:0]         idx8s;

   logic st32, st8w, st8s;
   assign st32 = start && (sel == 0);
   assign st8w = start && (sel == 1);
   assign st8s = start && (sel == 2);

   lin_rec_gen #(.WIDTH(32), .CW(8), .SATURATE(0)) dut32 (
      .__clock(clk), .__reset_n(reset_n), .__start(st32), .__ready(ready),
      .n(n_in), .seed_a(sa_in), .seed_b(sb_in), .coef_0(c0_in), .coef_1(c1_in),
      .__valid(v32), .__output_0(out32), .__index(idx32), .__done(d32), .__overflow(o32));

   lin_rec_gen #(.WIDTH(8), .CW(8), .SATURATE(0)) dut8w (
      .__clock(clk), .__reset_n(reset_n), .__start(st8w), .__ready(ready),
      .n(n_in[7:0]), .seed_a(sa_in[7:0]), .seed_b(sb_in[7:0]), .coef_0(c0_in), .coef_1(c1_in),
      .__valid(v8w), .__output_0(out8w), .__index(idx8w), .__done(d8w), .__overflow(o8w));

   lin_rec_gen #(.WIDTH(8), .CW(8), .SATURATE(1)) dut8s (
      .__clock(clk), .__reset_n(reset_n), .__start(st8s), .__ready(ready),
      .n(n_in[7:0]), .seed_a(sa_in[7:0]), .seed_b(sb_in[7:0]), .coef_0(c0_in), .coef_1(c1_in),
      .__valid(v8s), .__output_0(out8s), .__index(idx8s), .__done(d8s), .__overflow(o8s));

   // outputs of the selected instance, sign-extended term / zero-extended index
   logic   v_v, d_v, ov_v;
   longint out_v, idx_v;
   always_comb begin
      unique case (sel)
         1: begin v_v = v8w; d_v = d8w; ov_v = o8w; out_v = longint'(out8w); idx_v = longint'(idx8w); end
         2: begin v_v = v8s; d_v = d8s; ov_v = o8s; out_v = longint'(out8s); idx_v = longint'(idx8s); end
         default: begin v_v = v32; d_v = d32; ov_v = o32; out_v = longint'(out32); idx_v = longint'(idx32); end
      endcase
   end

   int npass = 0;
   int ntotal = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      ntotal++;
      if (act == exp) npass++;
      else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
   endtask

   // ---------------- behavioural model ----------------
   longint exp_v[$];
   bit     exp_cum[$];
   int     n_eff = 0;
   int     ptr = 0;
   bit     active = 1'b0;
   bit     finished = 1'b0;
   bit     rmode = 1'b0;

   function automatic void model_step(input longint a, input longint b, input longint c0,
                                      input longint c1, input int w, input bit sat,
                                      output longint v, output bit ovf);
      longint full, mx, mn, m;
      full = c1 * b + c0 * a;
      mx   = (longint'(1) <<< (w - 1)) - 1;
      mn   = -mx - 1;
      ovf  = (full > mx) || (full < mn);
      if (!ovf) v = full;
      else if (sat) v = (full > mx) ? mx : mn;
      else begin
         m = full & ((longint'(1) <<< w) - 1);
         if (m > mx) m -= (longint'(1) <<< w);
         v = m;
      end
   endfunction

   task automatic prep(input int s, input longint nn, input longint sa, input longint sb,
                       input longint c0, input longint c1);
      int     w;
      bit     sat;
      longint v;
      bit     o;
      w   = (s == 0) ? 32 : 8;
      sat = (s == 2);
      sel   = s;
      n_in  = 32'(nn);
      sa_in = 32'(sa);
      sb_in = 32'(sb);
      c0_in = 8'(c0);
      c1_in = 8'(c1);
      exp_v.delete();
      exp_cum.delete();
      n_eff = (nn > 0) ? int'(nn) : 0;
      for (int k = 0; k < n_eff; k++) begin
         if (k == 0) begin v = sa; o = 1'b0; end
         else if (k == 1) begin v = sb; o = 1'b0; end
         else model_step(exp_v[k-2], exp_v[k-1], c0, c1, w, sat, v, o);
         exp_v.push_back(v);
         exp_cum.push_back((k == 0) ? o : (exp_cum[k-1] | o));
      end
   endtask

   task automatic pin(input string nm, input longint lit[$]);
      for (int i = 0; i < lit.size(); i++)
         chk($sformatf("%s_model[%0d]", nm, i), (i < exp_v.size()) ? exp_v[i] : -999999, lit[i]);
   endtask

   // ---------------- compare process ----------------
   initial begin
      forever begin
         @(negedge clk);
         ready = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
         if (active && !finished) begin
            chk($sformatf("valid@%0d", ptr), longint'(v_v), longint'(ptr < n_eff));
            chk($sformatf("done@%0d", ptr), longint'(d_v), longint'(ptr >= n_eff));
            if (ptr < n_eff) begin
               chk($sformatf("term%0d", ptr), out_v, exp_v[ptr]);
               chk($sformatf("index%0d", ptr), idx_v, longint'(ptr));
               chk($sformatf("overflow@%0d", ptr), longint'(ov_v), longint'(exp_cum[ptr]));
               if (v_v && ready) ptr++;
            end else begin
               chk("overflow_final", longint'(ov_v),
                   (n_eff > 0) ? longint'(exp_cum[n_eff-1]) : 0);
               finished = 1'b1;
            end
         end
      end
   end

   task automatic launch(input bit mode);
      rmode = mode;
      @(posedge clk); #2 start = 1'b1;
      @(posedge clk); #2 start = 1'b0;
      ptr = 0; finished = 1'b0; active = 1'b1;
   endtask

   task automatic go(input bit mode, input int junk_at);
      launch(mode);
      for (int c = 0; c < 400 && !finished; c++) begin
         @(negedge clk);
         if (c == junk_at) begin
            #1 n_in = 32'd3; sa_in = 32'd77; sb_in = 32'd77; start = 1'b1;
            @(posedge clk); #2 start = 1'b0;
         end
      end
      chk("run_complete", longint'(finished), 1);
      active = 1'b0;
   endtask

   initial begin
      longint lit[$];
      int     s;
      longint nn, a0, b0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", longint'(v_v), 0);
      chk("rst_done", longint'(d_v), 0);
      chk("rst_overflow", longint'(ov_v), 0);
      chk("rst_out", out_v, 0);
      chk("rst_index", idx_v, 0);
      #1 reset_n = 1'b1;

      prep(0, 10, 0, 1, 1, 1);
      lit = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34};
      pin("fib", lit);
      go(1'b0, -1);

      prep(0, 10, 0, 1, 1, 1);
      go(1'b1, 3);

      prep(0, 0, 5, 6, 1, 1);
      go(1'b0, -1);
      prep(0, -3, 5, 6, 1, 1);
      go(1'b1, -1);

      prep(1, 14, 0, 1, 1, 1);
      chk("wrap_model_t12", exp_v[12], -112);
      chk("wrap_model_ovf11", longint'(exp_cum[11]), 0);
      chk("wrap_model_ovf12", longint'(exp_cum[12]), 1);
      go(1'b1, -1);

      prep(2, 14, 0, 1, 1, 1);
      chk("sat_model_t12", exp_v[12], 127);
      chk("sat_model_t13", exp_v[13], 127);
      go(1'b0, -1);

      prep(0, 5, 64'sd1073741824, 64'sd1073741824, 1, 1);
      go(1'b0, -1);
      prep(0, 6, 2, 1, 1, 1);
      lit = '{2, 1, 3, 4, 7, 11};
      pin("restart", lit);
      go(1'b1, -1);

      prep(0, 4, 3, 5, 2, -1);
      prep(0, 4, 3, 5, -1, 2);
      lit = '{3, 5, 7, 9};
      pin("lin", lit);
      go(1'b1, -1);

      for (int r = 0; r < 12; r++) begin
         s  = int'($urandom_range(0, 2));
         nn = longint'($urandom_range(0, 14)) - 2;
         a0 = (s == 0) ? longint'($urandom_range(0, 2000)) - 1000 : longint'($urandom_range(0, 200)) - 100;
         b0 = (s == 0) ? longint'($urandom_range(0, 2000)) - 1000 : longint'($urandom_range(0, 200)) - 100;
         prep(s, nn, a0, b0, longint'($urandom_range(0, 16)) - 8, longint'($urandom_range(0, 16)) - 8);
         go(1'b1, -1);
      end

      prep(0, 10, 0, 1, 1, 1);
      launch(1'b0);
      for (int c = 0; c < 50 && ptr < 4; c++) @(negedge clk);
      chk("reached_term4", longint'(ptr >= 4), 1);
      active = 1'b0;
      #1 reset_n = 1'b0;
      @(negedge clk);
      chk("midrst_valid", longint'(v_v), 0);
      chk("midrst_done", longint'(d_v), 0);
      chk("midrst_overflow", longint'(ov_v), 0);
      chk("midrst_out", out_v, 0);
      chk("midrst_index", idx_v, 0);
      #1 reset_n = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("idle_valid", longint'(v_v), 0);
         chk("idle_done", longint'(d_v), 0);
      end

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
